// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with byte strobes, a per-register pending scoreboard and optional write-to-read forwarding.
// Reads are combinational; writes and scoreboard updates land on the rising edge, and rst clears everything asynchronously.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rbusy,
  input  logic                  wen_a,
  input  logic                  wen_b,
  input  logic [ADDR_W-1:0]     waddr_a,
  input  logic [ADDR_W-1:0]     waddr_b,
  input  logic [DATA_W-1:0]     wdata_a,
  input  logic [DATA_W-1:0]     wdata_b,
  input  logic [DATA_W/8-1:0]   wstrb_a,
  input  logic [DATA_W/8-1:0]   wstrb_b,
  input  logic                  wclr_a,
  input  logic                  wclr_b,
  input  logic                  set_en,
  input  logic [ADDR_W-1:0]     set_addr,
  output logic [DATA_W-1:0]     dbg_wdata_a,
  output logic [DATA_W-1:0]     dbg_wdata_b
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  logic [DEPTH-1:0]  clr_hit;
  logic [DEPTH-1:0]  set_hit;
  logic [DATA_W-1:0] merged_a;
  logic [DATA_W-1:0] merged_b;
  logic              wa_act;
  logic              wb_act;

  assign wa_act = wen_a && (waddr_a != '0);
  assign wb_act = wen_b && (waddr_b != '0);

  // Port B is applied after port A so it wins any lane both ports strobe.
  // regs_d doubles as the forwarding source, since it is the combined result.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      for (int k = 0; k < NB; k++) begin
        if (wa_act && (waddr_a == ADDR_W'(i)) && wstrb_a[k])
          regs_d[i][8*k +: 8] = wdata_a[8*k +: 8];
        if (wb_act && (waddr_b == ADDR_W'(i)) && wstrb_b[k])
          regs_d[i][8*k +: 8] = wdata_b[8*k +: 8];
      end
    end
    regs_d[0] = '0;
  end

  // Clears apply regardless of strobes; a same-cycle set overrides a clear.
  always_comb begin
    clr_hit = '0;
    set_hit = '0;
    for (int i = 1; i < DEPTH; i++) begin
      clr_hit[i] = (wen_a && wclr_a && (waddr_a == ADDR_W'(i))) ||
                   (wen_b && wclr_b && (waddr_b == ADDR_W'(i)));
      set_hit[i] = set_en && (set_addr == ADDR_W'(i));
    end
    pend_d = (pend_q & ~clr_hit) | set_hit;
  end

  always_comb begin
    merged_a = '0;
    merged_b = '0;
    for (int k = 0; k < NB; k++) begin
      merged_a[8*k +: 8] = wstrb_a[k] ? wdata_a[8*k +: 8] : regs_q[waddr_a][8*k +: 8];
      merged_b[8*k +: 8] = wstrb_b[k] ? wdata_b[8*k +: 8] : regs_q[waddr_b][8*k +: 8];
    end
  end

  assign dbg_wdata_a = wen_a ? merged_a : '0;
  assign dbg_wdata_b = wen_b ? merged_b : '0;

  always_comb begin
    logic [ADDR_W-1:0] ra;
    ra    = '0;
    rdata = '0;
    rbusy = '0;
    for (int p = 0; p < NRD; p++) begin
      ra = raddr[p*ADDR_W +: ADDR_W];
      if (!rst) begin
        rdata[p*DATA_W +: DATA_W] = (BYPASS != 0) ? regs_d[ra] : regs_q[ra];
        rbusy[p] = pend_q[ra] & ~((BYPASS != 0) & clr_hit[ra] & ~set_hit[ra]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      pend_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      pend_q <= pend_d & ~DEPTH'(1);
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: expected values are queued when stimulus is driven and popped when the DUT output is sampled.
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 2;

  logic                  clk;
  logic                  rst;
  logic [NRD*ADDR_W-1:0] raddr;
  logic [NRD*DATA_W-1:0] rdata;
  logic [NRD-1:0]        rbusy;
  logic                  wen_a, wen_b;
  logic [ADDR_W-1:0]     waddr_a, waddr_b;
  logic [DATA_W-1:0]     wdata_a, wdata_b;
  logic [DATA_W/8-1:0]   wstrb_a, wstrb_b;
  logic                  wclr_a, wclr_b;
  logic                  set_en;
  logic [ADDR_W-1:0]     set_addr;
  logic [DATA_W-1:0]     dbg_wdata_a, dbg_wdata_b;

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen_a(wen_a), .wen_b(wen_b), .waddr_a(waddr_a), .waddr_b(waddr_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b), .wstrb_a(wstrb_a), .wstrb_b(wstrb_b),
    .wclr_a(wclr_a), .wclr_b(wclr_b), .set_en(set_en), .set_addr(set_addr),
    .dbg_wdata_a(dbg_wdata_a), .dbg_wdata_b(dbg_wdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic check_next(input logic [31:0] observed);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=none", observed);
    end else begin
      e = exp_q.pop_front();
      assert (observed === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, observed, e.val);
      end
    end
  endtask

  task automatic idle();
    wen_a = 0; wen_b = 0; waddr_a = '0; waddr_b = '0;
    wdata_a = '0; wdata_b = '0; wstrb_a = '0; wstrb_b = '0;
    wclr_a = 0; wclr_b = 0; set_en = 0; set_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd(input int p);
    return rdata[p*DATA_W +: DATA_W];
  endfunction

  function automatic logic [31:0] bz(input int p);
    return {31'd0, rbusy[p]};
  endfunction

  task automatic set_raddr(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    raddr = {a1, a0};
  endtask

  initial begin
    idle();
    rst = 1'b1;
    set_raddr(5'd3, 5'd5);
    #12;
    expect_val("reset_rdata", 32'h0);
    expect_val("reset_rbusy", 32'h0);
    check_next(rdata[31:0] | rdata[63:32]);
    check_next({30'd0, rbusy});
    rst = 1'b0;
    tick();

    // Full-word write to reg 3 with same-cycle forwarding and debug word
    wen_a = 1; waddr_a = 5'd3; wdata_a = 32'h12345678; wstrb_a = 4'hF;
    set_raddr(5'd3, 5'd5);
    #1;
    expect_val("dbg_full_write", 32'h12345678);
    expect_val("bypass_full_write", 32'h12345678);
    check_next(dbg_wdata_a);
    check_next(rd(0));
    tick(); idle(); #1;
    expect_val("read_after_write", 32'h12345678);
    expect_val("dbg_idle_zero", 32'h0);
    check_next(rd(0));
    check_next(dbg_wdata_a);

    // Partial strobe merge
    wen_a = 1; waddr_a = 5'd3; wdata_a = 32'hAABBCCDD; wstrb_a = 4'h2;
    #1;
    expect_val("dbg_partial", 32'h1234CC78);
    check_next(dbg_wdata_a);
    tick(); idle(); #1;
    expect_val("read_partial", 32'h1234CC78);
    check_next(rd(0));

    // Zero-strobe write leaves data unchanged
    wen_a = 1; waddr_a = 5'd3; wdata_a = 32'hFFFFFFFF; wstrb_a = 4'h0;
    #1;
    expect_val("dbg_zero_strobe", 32'h1234CC78);
    check_next(dbg_wdata_a);
    tick(); idle(); #1;
    expect_val("read_zero_strobe", 32'h1234CC78);
    check_next(rd(0));

    // Dual-port collision: B wins its lanes, A keeps the rest
    wen_a = 1; waddr_a = 5'd5; wdata_a = 32'h11111111; wstrb_a = 4'hF;
    wen_b = 1; waddr_b = 5'd5; wdata_b = 32'h22222222; wstrb_b = 4'h3;
    set_raddr(5'd3, 5'd5);
    #1;
    expect_val("bypass_collision", 32'h11112222);
    check_next(rd(1));
    tick(); idle(); #1;
    expect_val("read_collision", 32'h11112222);
    check_next(rd(1));

    // Scoreboard set / clear / set-wins
    set_en = 1; set_addr = 5'd7;
    set_raddr(5'd7, 5'd3);
    #1;
    expect_val("busy_before_set_edge", 32'h0);
    check_next(bz(0));
    tick(); idle(); #1;
    expect_val("busy_after_set", 32'h1);
    expect_val("busy_other_port", 32'h0);
    check_next(bz(0));
    check_next(bz(1));
    wen_a = 1; waddr_a = 5'd7; wclr_a = 1; wstrb_a = 4'h0;
    #1;
    expect_val("busy_clear_bypass", 32'h0);
    check_next(bz(0));
    tick(); idle(); #1;
    expect_val("busy_after_clear", 32'h0);
    check_next(bz(0));
    set_en = 1; set_addr = 5'd7;
    wen_b = 1; waddr_b = 5'd7; wclr_b = 1; wdata_b = 32'hCAFEF00D; wstrb_b = 4'hF;
    tick(); idle(); #1;
    expect_val("busy_set_wins", 32'h1);
    expect_val("read_clear_write", 32'hCAFEF00D);
    check_next(bz(0));
    check_next(rd(0));
    set_en = 1; set_addr = 5'd7;
    wen_a = 1; waddr_a = 5'd7; wclr_a = 1;
    #1;
    expect_val("busy_set_blocks_bypass", 32'h1);
    check_next(bz(0));
    tick(); idle(); #1;

    // Register 0 ignores writes and sets
    wen_a = 1; waddr_a = 5'd0; wdata_a = 32'hFFFFFFFF; wstrb_a = 4'hF;
    set_en = 1; set_addr = 5'd0;
    set_raddr(5'd0, 5'd0);
    #1;
    expect_val("reg0_bypass", 32'h0);
    check_next(rd(0));
    tick(); idle(); #1;
    expect_val("reg0_read", 32'h0);
    expect_val("reg0_busy", 32'h0);
    check_next(rd(0));
    check_next(bz(0));

    // Asynchronous reset between edges
    set_raddr(5'd3, 5'd7);
    #1;
    expect_val("pre_reset_reg3", 32'h1234CC78);
    expect_val("pre_reset_busy7", 32'h1);
    check_next(rd(0));
    check_next(bz(1));
    rst = 1'b1;
    #1;
    expect_val("async_rst_rdata0", 32'h0);
    expect_val("async_rst_rdata1", 32'h0);
    expect_val("async_rst_rbusy", 32'h0);
    check_next(rd(0));
    check_next(rd(1));
    check_next({30'd0, rbusy});

    // Writes during reset are discarded
    wen_a = 1; waddr_a = 5'd9; wdata_a = 32'hDEADBEEF; wstrb_a = 4'hF;
    set_en = 1; set_addr = 5'd9;
    tick();
    idle();
    rst = 1'b0;
    set_raddr(5'd9, 5'd7);
    #1;
    expect_val("rst_write_dropped", 32'h0);
    expect_val("rst_set_dropped", 32'h0);
    expect_val("rst_cleared_busy7", 32'h0);
    check_next(rd(0));
    check_next(bz(0));
    check_next(bz(1));

    // First edge after reset accepts a write
    wen_b = 1; waddr_b = 5'd9; wdata_b = 32'h0BADF00D; wstrb_b = 4'hF;
    tick(); idle(); #1;
    expect_val("post_reset_write", 32'h0BADF00D);
    check_next(rd(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 5, address width; depth = 2**ADDR_W registers.
REQ-003 Parameter NRD, default 2, number of read ports; range 1..4.
REQ-004 Parameter BYPASS, default 1; 1 = write-to-read forwarding enabled, 0 = disabled.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 raddr  in  NRD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W].
REQ-008 rdata  out  NRD*DATA_W  read data; port i at bits [i*DATA_W +: DATA_W].
REQ-009 rbusy  out  NRD  port i high when its addressed register is pending in the scoreboard.
REQ-010 wen_a, wen_b  in  1 each  write enables, ports A and B.
REQ-011 waddr_a, waddr_b  in  ADDR_W each  write addresses.
REQ-012 wdata_a, wdata_b  in  DATA_W each  write data.
REQ-013 wstrb_a, wstrb_b  in  DATA_W/8 each  byte-lane strobes; bit k covers bits [8k+7:8k].
REQ-014 wclr_a, wclr_b  in  1 each  when set with the matching wen, the write also clears the register's pending bit.
REQ-015 set_en  in  1, set_addr  in  ADDR_W  marks a register pending (outstanding load).
REQ-016 dbg_wdata_a, dbg_wdata_b  out  DATA_W each  merged word each port writes this cycle.

Function
REQ-017 Register 0 SHALL always read 0; writes and sets to address 0 SHALL be ignored.
REQ-018 Merged word for a port: lane k = wdata lane k if strobe k, else current register lane k; dbg_wdata_x SHALL show it combinationally whenever wen_x=1, else 0.
REQ-019 A write with wen=1, address != 0 and strobe != 0 SHALL update the register at the next rising edge.
REQ-020 A write with strobe = 0 SHALL leave data unchanged but SHALL still apply wclr.
REQ-021 Both ports, same address, same cycle: per lane, B's data SHALL win where wstrb_b set, else A's where wstrb_a set, else old value.
REQ-022 Reads SHALL be combinational; latency 0 cycles from raddr to rdata.
REQ-023 BYPASS=1: a read matching an active write address (not 0) SHALL return the final combined value of REQ-021 in the same cycle; BYPASS=0: old contents until the edge.
REQ-024 Scoreboard: one pending bit per register; set_en sets the bit at the next edge.
REQ-025 wclr_a/wclr_b with wen SHALL clear the bit at the next edge.
REQ-026 set_en and a clearing write to the same register in one cycle: set SHALL win (bit ends 1).
REQ-027 rbusy[i] SHALL reflect the registered pending bit; BYPASS=1: same-cycle clearing write to that address SHALL force rbusy[i]=0 unless set_en targets the same address.
REQ-028 Bit 0 of scoreboard SHALL read 0 at all times.

Reset
REQ-029 rst=1 SHALL asynchronously clear all registers to 0 and all pending bits to 0, independent of clk.
REQ-030 While rst=1: rdata = 0 on all ports, rbusy = 0, writes and sets SHALL be ignored.
REQ-031 After rst deasserts, the first rising edge SHALL accept writes normally; rst asserted mid-write SHALL discard that write.

Verification
REQ-032 Reset then write A: addr 3, data 0x12345678, strb 0xF; next cycle read port 0 addr 3 -> 0x12345678; dbg_wdata_a = 0x12345678 during write.
REQ-033 Reg 3 = 0x12345678; write A strb 0x2, data 0xAABBCCDD -> reg 3 = 0x1234CC78; dbg_wdata_a = 0x1234CC78.
REQ-034 Same cycle A (addr 5, 0x11111111, strb 0xF) and B (addr 5, 0x22222222, strb 0x3) -> reg 5 = 0x11112222; with BYPASS=1 read of addr 5 that cycle = 0x11112222.
REQ-035 set_en addr 7; next cycle raddr 7 -> rbusy=1; write A addr 7 wclr_a=1 -> rbusy=0 same cycle (BYPASS=1), stays 0 after edge; simultaneous set_en+clear on addr 7 -> rbusy=1 after edge.
REQ-036 Write addr 0 data 0xFFFFFFFF and set_en addr 0 -> read addr 0 = 0, rbusy = 0.
REQ-037 Registers loaded non-zero and pending bits set; pulse rst between edges -> rdata = 0 and rbusy = 0 immediately, without a clock edge.
